// File: rtl/regbank_read_initiator_pkg.sv
// Shared types and constants for the register-bank operand-fetch initiator.
// Holds the FSM encoding, operand slot indices and the lowest-bit selector.
package regbank_read_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    REQ     = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_t;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;

  localparam logic [31:0] TIMEOUT_FILL = 32'h0;

  // Reads always go A, B, C, so the next slot is the lowest pending bit.
  function automatic logic [1:0] lowest_bit(input logic [2:0] m);
    if (m[0])      return OP_A;
    else if (m[1]) return OP_B;
    else           return OP_C;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single self-timed handshake line.
// Both flops reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/regbank_read_initiator.sv
// Operand-fetch initiator: issues transition-signalled reads to the register
// bank for up to three operands and hands the bundle to issue over valid/ready.
module regbank_read_initiator
  import regbank_read_initiator_pkg::*;
#(
  parameter int ADDR_SETUP  = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_addr_a,
  input  logic [3:0]  req_addr_b,
  input  logic [3:0]  req_addr_c,
  input  logic [2:0]  req_mask,
  output logic        rb_trigger,
  output logic [3:0]  rb_addr,
  input  logic        rb_ready,
  input  logic [31:0] rb_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic        op_err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYC);

  if (TIMEOUT_CYC > (2**CNT_W - 1) || TIMEOUT_CYC <= SETTLE_CYC || ADDR_SETUP < 1
      || ADDR_SETUP > 2**CNT_W) begin : g_param_check
    $error("regbank_read_initiator: ADDR_SETUP/SETTLE_CYC/TIMEOUT_CYC out of range");
  end

  state_t           state, state_nx;
  logic [2:0]       mask, mask_rem, sel_bit;
  logic [3:0]       addr_a, addr_b, addr_c;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt, setup_cnt, elapsed;
  logic             low_seen, timed_out, sync_ready;
  logic             done_ok, timeout_hit;

  function automatic logic [3:0] pick_addr(input logic [1:0] s, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c);
    case (s)
      OP_A:    return a;
      OP_B:    return b;
      default: return c;
    endcase
  endfunction

  sync2 u_sync_ready (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rb_ready),
    .q     (sync_ready)
  );

  assign req_ready = (state == IDLE);
  assign op_valid  = (state == OUT);

  // elapsed counts the current WAIT cycle, so a read lasts at most TIMEOUT_CYC cycles
  always_comb begin
    sel_bit     = 3'b001 << sel;
    mask_rem    = mask & ~sel_bit;
    elapsed     = (cnt == TIMEOUT_C) ? cnt : cnt + 1'b1;
    done_ok     = sync_ready && (low_seen || elapsed >= SETTLE_C);
    timeout_hit = (elapsed >= TIMEOUT_C);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (req_mask == 3'b000) ? OUT : SETUP;
      SETUP:   if (setup_cnt == SETUP_LAST) state_nx = REQ;
      REQ:     state_nx = WAIT;
      WAIT:    if (done_ok || timeout_hit) state_nx = CAPTURE;
      CAPTURE: state_nx = (mask_rem != 3'b000) ? SETUP : OUT;
      OUT:     if (op_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask       <= 3'b000;
      addr_a     <= 4'd0;
      addr_b     <= 4'd0;
      addr_c     <= 4'd0;
      sel        <= OP_A;
      cnt        <= '0;
      setup_cnt  <= '0;
      low_seen   <= 1'b0;
      timed_out  <= 1'b0;
      rb_trigger <= 1'b0;
      rb_addr    <= 4'd0;
      op_a       <= 32'h0;
      op_b       <= 32'h0;
      op_c       <= 32'h0;
      op_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          mask      <= req_mask;
          addr_a    <= req_addr_a;
          addr_b    <= req_addr_b;
          addr_c    <= req_addr_c;
          op_a      <= 32'h0;
          op_b      <= 32'h0;
          op_c      <= 32'h0;
          op_err    <= 1'b0;
          sel       <= lowest_bit(req_mask);
          setup_cnt <= '0;
          if (req_mask != 3'b000)
            rb_addr <= pick_addr(lowest_bit(req_mask), req_addr_a, req_addr_b, req_addr_c);
        end
        SETUP: setup_cnt <= setup_cnt + 1'b1;
        REQ: begin
          rb_trigger <= ~rb_trigger;
          cnt        <= '0;
          low_seen   <= 1'b0;
          timed_out  <= 1'b0;
        end
        WAIT: begin
          cnt <= elapsed;
          if (!sync_ready) low_seen <= 1'b1;
          if (timeout_hit && !done_ok) begin
            timed_out <= 1'b1;
            op_err    <= 1'b1;
          end
        end
        // rb_data is stable here by bank contract, so it is sampled directly
        CAPTURE: begin
          case (sel)
            OP_A:    op_a <= timed_out ? TIMEOUT_FILL : rb_data;
            OP_B:    op_b <= timed_out ? TIMEOUT_FILL : rb_data;
            default: op_c <= timed_out ? TIMEOUT_FILL : rb_data;
          endcase
          mask <= mask_rem;
          if (mask_rem != 3'b000) begin
            sel       <= lowest_bit(mask_rem);
            rb_addr   <= pick_addr(lowest_bit(mask_rem), addr_a, addr_b, addr_c);
            setup_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_read_initiator.sv
// Bench for regbank_read_initiator: behavioural bank model, directed requests,
// and a scoreboard monitor that checks each delivered operand bundle.
module tb_regbank_read_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr_a = 4'd0, req_addr_b = 4'd0, req_addr_c = 4'd0;
  logic [2:0]  req_mask = 3'b000;
  logic        rb_trigger;
  logic [3:0]  rb_addr;
  logic        rb_ready = 1'b1;
  logic [31:0] rb_data = 32'h0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] op_a, op_b, op_c;
  logic        op_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          trig_cnt = 0;
  int          bank_mode = 0;
  logic [31:0] mem [16];

  regbank_read_initiator #(
    .ADDR_SETUP  (1),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_addr_c (req_addr_c),
    .req_mask   (req_mask),
    .rb_trigger (rb_trigger),
    .rb_addr    (rb_addr),
    .rb_ready   (rb_ready),
    .rb_data    (rb_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_c       (op_c),
    .op_err     (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bank: mode 0 normal (ready back 3 clk later), 1 short low pulse, 2 never responds
  always @(rb_trigger) begin
    trig_cnt++;
    case (bank_mode)
      0: begin
        #1 rb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rb_data = mem[rb_addr];
        rb_ready = 1'b1;
      end
      1: begin
        #1 rb_ready = 1'b0;
        rb_data = mem[rb_addr];
        #3 rb_ready = 1'b1;
      end
      default: #1 rb_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op_a", op_a, e.a);
        chk("op_b", op_b, e.b);
        chk("op_c", op_c, e.c);
        chk("op_err", {31'd0, op_err}, {31'd0, e.err});
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [2:0] m, input bit push, input logic [31:0] ea,
                      input logic [31:0] eb, input logic [31:0] ec, input logic ee);
    bit ok = 0;
    if (push) sb.push_back('{a: ea, b: eb, c: ec, err: ee});
    @(posedge clk); #1;
    req_addr_a = a; req_addr_b = b; req_addr_c = c; req_mask = m;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      req_valid = 1'b0;
      chk("req_accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("bundle_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rb_trigger"}, {31'd0, rb_trigger}, 32'd0);
    chk({tag, "_rb_addr"}, {28'd0, rb_addr}, 32'd0);
    chk({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_op_c"}, op_c, 32'd0);
    chk({tag, "_op_err"}, {31'd0, op_err}, 32'd0);
  endtask

  initial begin
    int base;
    logic [31:0] sa, sb_, sc;
    logic se;
    bit stable, rr_low, seen;

    for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);

    repeat (3) @(posedge clk);
    #2 chk_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // All three operands
    base = trig_cnt;
    send(4'd0, 4'd3, 4'd9, 3'b111, 1, 32'd1, 32'd4, 32'd10, 1'b0);
    drain(300);
    chk("trig_count_abc", 32'(trig_cnt - base), 32'd3);

    // C only
    base = trig_cnt;
    send(4'd1, 4'd2, 4'd5, 3'b100, 1, 32'd0, 32'd0, 32'd6, 1'b0);
    drain(300);
    chk("trig_count_c", 32'(trig_cnt - base), 32'd1);

    // Empty mask: bundle of zeros with no bank traffic
    base = trig_cnt;
    send(4'd7, 4'd7, 4'd7, 3'b000, 1, 32'd0, 32'd0, 32'd0, 1'b0);
    drain(20);
    chk("trig_count_none", 32'(trig_cnt - base), 32'd0);

    // Duplicate addresses are read twice
    base = trig_cnt;
    send(4'd6, 4'd6, 4'd0, 3'b011, 1, 32'd7, 32'd7, 32'd0, 1'b0);
    drain(300);
    chk("trig_count_dup", 32'(trig_cnt - base), 32'd2);

    // Ready low pulse too short to be sampled: completes on settle time
    bank_mode = 1;
    send(4'd2, 4'd0, 4'd0, 3'b001, 1, 32'd3, 32'd0, 32'd0, 1'b0);
    drain(300);
    bank_mode = 0;
    repeat (4) @(posedge clk);

    // Bank never answers: both reads time out
    bank_mode = 2;
    base = trig_cnt;
    send(4'd4, 4'd5, 4'd0, 3'b011, 1, 32'd0, 32'd0, 32'd0, 1'b1);
    drain(400);
    chk("trig_count_timeout", 32'(trig_cnt - base), 32'd2);
    bank_mode = 0;
    #1 rb_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Back-pressure on the output
    op_ready = 1'b0;
    send(4'd4, 4'd5, 4'd0, 3'b011, 1, 32'd5, 32'd6, 32'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (op_valid) begin seen = 1; break; end
    end
    chk("bp_op_valid_seen", {31'd0, seen}, 32'd1);
    sa = op_a; sb_ = op_b; sc = op_c; se = op_err;
    base = trig_cnt;
    stable = 1; rr_low = 1;
    repeat (20) begin
      @(negedge clk);
      if (!op_valid || op_a !== sa || op_b !== sb_ || op_c !== sc || op_err !== se)
        stable = 0;
      if (req_ready) rr_low = 0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_req_ready_low", {31'd0, rr_low}, 32'd1);
    chk("bp_no_trigger", 32'(trig_cnt - base), 32'd0);
    @(posedge clk); #1 op_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {31'd0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, op_valid}, 32'd0);
    drain(5);

    // Reset during the second operand's wait
    base = trig_cnt;
    send(4'd1, 4'd2, 4'd3, 3'b111, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (trig_cnt - base >= 2) break;
    end
    chk("rst_reached_op2", {31'd0, (trig_cnt - base >= 2)}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #2 chk_reset_vals("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    send(4'd7, 4'd8, 4'd0, 3'b011, 1, 32'd8, 32'd9, 32'd0, 1'b0);
    drain(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
